// File: rtl/uart_core.sv
// Byte-wide 8N1 UART with a runtime bit-period divider and a one-byte receive buffer.
// Define UART_PARITY_EN for 8E1 framing with rx_parity_err and frame_err outputs.
`timescale 1ns/1ps
module uart_core #(
    parameter int DIV_MIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_divider,
    input  logic        ser_rx,
    output logic        ser_tx,
    input  logic [7:0]  reg_dat_di,
    input  logic        reg_dat_we,
    input  logic        reg_dat_re,
    output logic [7:0]  reg_dat_do,
    output logic        tx_busy,
    output logic        rx_valid,
    output logic        rx_overrun
`ifdef UART_PARITY_EN
    ,
    output logic        rx_parity_err,
    output logic        frame_err
`endif
);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4,
        RX_WAIT  = 3'd5
    } rx_state_t;

`ifdef UART_PARITY_EN
    function automatic logic even_parity(input logic [7:0] data);
        even_parity = ^data;
    endfunction
`endif

    logic [15:0] div_eff_s;
    assign div_eff_s = (cfg_divider < 16'(DIV_MIN)) ? 16'(DIV_MIN) : cfg_divider;

    // ---------------- transmitter ----------------
    tx_state_t   tx_state_r, tx_state_n;
    logic [15:0] tx_cnt_r, tx_cnt_n, tx_period_r, tx_period_n;
    logic [2:0]  tx_idx_r, tx_idx_n;
    logic [7:0]  tx_shift_r, tx_shift_n;
    logic        tx_bit_end_s;
    logic        ser_tx_r, ser_tx_n, tx_busy_r, tx_busy_n;
`ifdef UART_PARITY_EN
    logic        tx_par_r, tx_par_n;
`endif

    assign tx_bit_end_s = (tx_cnt_r == (tx_period_r - 16'd1));

    // TX state register with registered line and busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r  <= TX_IDLE;
            tx_cnt_r    <= 16'd0;
            tx_period_r <= 16'd0;
            tx_idx_r    <= 3'd0;
            tx_shift_r  <= 8'd0;
            ser_tx_r    <= 1'b1;
            tx_busy_r   <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_r    <= 1'b0;
`endif
        end else begin
            tx_state_r  <= tx_state_n;
            tx_cnt_r    <= tx_cnt_n;
            tx_period_r <= tx_period_n;
            tx_idx_r    <= tx_idx_n;
            tx_shift_r  <= tx_shift_n;
            ser_tx_r    <= ser_tx_n;
            tx_busy_r   <= tx_busy_n;
`ifdef UART_PARITY_EN
            tx_par_r    <= tx_par_n;
`endif
        end
    end

    // TX next-state: each frame bit lasts exactly tx_period_r clocks
    always_comb begin
        tx_state_n  = tx_state_r;
        tx_cnt_n    = tx_cnt_r + 16'd1;
        tx_period_n = tx_period_r;
        tx_idx_n    = tx_idx_r;
        tx_shift_n  = tx_shift_r;
`ifdef UART_PARITY_EN
        tx_par_n    = tx_par_r;
`endif
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_n = 16'd0;
                if (reg_dat_we) begin
                    tx_state_n  = TX_START;
                    tx_shift_n  = reg_dat_di;
                    tx_period_n = div_eff_s;
`ifdef UART_PARITY_EN
                    tx_par_n    = even_parity(reg_dat_di);
`endif
                end else begin
                    tx_state_n = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_bit_end_s) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = 16'd0;
                    tx_idx_n   = 3'd0;
                end else begin
                    tx_state_n = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_bit_end_s) begin
                    tx_cnt_n   = 16'd0;
                    tx_shift_n = {1'b0, tx_shift_r[7:1]};
                    if (tx_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_n = TX_PAR;
`else
                        tx_state_n = TX_STOP;
`endif
                    end else begin
                        tx_idx_n = tx_idx_r + 3'd1;
                    end
                end else begin
                    tx_state_n = TX_DATA;
                end
            end
            TX_PAR: begin
                if (tx_bit_end_s) begin
                    tx_state_n = TX_STOP;
                    tx_cnt_n   = 16'd0;
                end else begin
                    tx_state_n = TX_PAR;
                end
            end
            TX_STOP: begin
                if (tx_bit_end_s) begin
                    tx_state_n = TX_IDLE;
                    tx_cnt_n   = 16'd0;
                end else begin
                    tx_state_n = TX_STOP;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                tx_cnt_n   = 16'd0;
            end
        endcase
    end

    // TX outputs derived from the upcoming state so they register alongside it
    always_comb begin
        tx_busy_n = (tx_state_n != TX_IDLE);
        case (tx_state_n)
            TX_IDLE:  ser_tx_n = 1'b1;
            TX_START: ser_tx_n = 1'b0;
            TX_DATA:  ser_tx_n = tx_shift_n[0];
`ifdef UART_PARITY_EN
            TX_PAR:   ser_tx_n = tx_par_n;
`endif
            TX_STOP:  ser_tx_n = 1'b1;
            default:  ser_tx_n = 1'b1;
        endcase
    end

    assign ser_tx  = ser_tx_r;
    assign tx_busy = tx_busy_r;

    // ---------------- receiver ----------------
    rx_state_t   rx_state_r, rx_state_n;
    logic [15:0] rx_cnt_r, rx_cnt_n, rx_period_r, rx_period_n;
    logic [2:0]  rx_idx_r, rx_idx_n;
    logic [7:0]  rx_shift_r, rx_shift_n;
    logic        rx_sync1_r, rx_sync2_r, rx_prev_r;
    logic        rx_fall_s, rx_half_end_s, rx_bit_end_s, rx_done_s, rx_pop_s;
    logic [7:0]  rx_data_r, rx_data_n;
    logic        rx_valid_r, rx_valid_n, rx_ovr_r, rx_ovr_n;
`ifdef UART_PARITY_EN
    logic        rx_par_bad_r, rx_par_bad_n, rx_perr_r, rx_perr_n;
    logic        rx_ferr_s, frame_err_r;
`endif

    assign rx_fall_s     = rx_prev_r & ~rx_sync2_r;
    assign rx_half_end_s = (rx_cnt_r == ({1'b0, rx_period_r[15:1]} - 16'd1));
    assign rx_bit_end_s  = (rx_cnt_r == (rx_period_r - 16'd1));
    assign rx_pop_s      = reg_dat_re & rx_valid_r;

    // RX synchroniser, state register and receive buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1_r  <= 1'b1;
            rx_sync2_r  <= 1'b1;
            rx_prev_r   <= 1'b1;
            rx_state_r  <= RX_IDLE;
            rx_cnt_r    <= 16'd0;
            rx_period_r <= 16'd0;
            rx_idx_r    <= 3'd0;
            rx_shift_r  <= 8'd0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            rx_ovr_r    <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad_r <= 1'b0;
            rx_perr_r    <= 1'b0;
            frame_err_r  <= 1'b0;
`endif
        end else begin
            rx_sync1_r  <= ser_rx;
            rx_sync2_r  <= rx_sync1_r;
            rx_prev_r   <= rx_sync2_r;
            rx_state_r  <= rx_state_n;
            rx_cnt_r    <= rx_cnt_n;
            rx_period_r <= rx_period_n;
            rx_idx_r    <= rx_idx_n;
            rx_shift_r  <= rx_shift_n;
            rx_data_r   <= rx_data_n;
            rx_valid_r  <= rx_valid_n;
            rx_ovr_r    <= rx_ovr_n;
`ifdef UART_PARITY_EN
            rx_par_bad_r <= rx_par_bad_n;
            rx_perr_r    <= rx_perr_n;
            frame_err_r  <= rx_ferr_s;
`endif
        end
    end

    // RX next-state: start bit checked at half period, later bits one period apart
    always_comb begin
        rx_state_n  = rx_state_r;
        rx_cnt_n    = rx_cnt_r + 16'd1;
        rx_period_n = rx_period_r;
        rx_idx_n    = rx_idx_r;
        rx_shift_n  = rx_shift_r;
        rx_done_s   = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_bad_n = rx_par_bad_r;
        rx_ferr_s    = 1'b0;
`endif
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_n = 16'd0;
                if (rx_fall_s) begin
                    rx_state_n  = RX_START;
                    rx_period_n = div_eff_s;
                end else begin
                    rx_state_n = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_half_end_s) begin
                    rx_cnt_n   = 16'd0;
                    rx_idx_n   = 3'd0;
                    rx_state_n = rx_sync2_r ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_n = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_bit_end_s) begin
                    rx_cnt_n   = 16'd0;
                    rx_shift_n = {rx_sync2_r, rx_shift_r[7:1]};
                    if (rx_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_n = RX_PAR;
`else
                        rx_state_n = RX_STOP;
`endif
                    end else begin
                        rx_idx_n = rx_idx_r + 3'd1;
                    end
                end else begin
                    rx_state_n = RX_DATA;
                end
            end
            RX_PAR: begin
                if (rx_bit_end_s) begin
                    rx_cnt_n   = 16'd0;
                    rx_state_n = RX_STOP;
`ifdef UART_PARITY_EN
                    rx_par_bad_n = rx_sync2_r ^ even_parity(rx_shift_r);
`endif
                end else begin
                    rx_state_n = RX_PAR;
                end
            end
            RX_STOP: begin
                if (rx_bit_end_s) begin
                    rx_cnt_n = 16'd0;
                    if (rx_sync2_r) begin
                        rx_done_s  = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        // bad stop: park until the line idles so a held-low line cannot retrigger
                        rx_state_n = RX_WAIT;
`ifdef UART_PARITY_EN
                        rx_ferr_s  = 1'b1;
`endif
                    end
                end else begin
                    rx_state_n = RX_STOP;
                end
            end
            RX_WAIT: begin
                rx_cnt_n   = 16'd0;
                rx_state_n = rx_sync2_r ? RX_IDLE : RX_WAIT;
            end
            default: begin
                rx_cnt_n   = 16'd0;
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    // Receive buffer: a pop on the completion clock makes room for the new byte
    always_comb begin
        rx_data_n  = rx_data_r;
        rx_valid_n = rx_valid_r;
        rx_ovr_n   = rx_ovr_r;
        if (rx_done_s) begin
            if (!rx_valid_r || reg_dat_re) begin
                rx_data_n  = rx_shift_r;
                rx_valid_n = 1'b1;
                rx_ovr_n   = rx_pop_s ? 1'b0 : rx_ovr_r;
            end else begin
                rx_ovr_n = 1'b1;
            end
        end else if (rx_pop_s) begin
            rx_valid_n = 1'b0;
            rx_ovr_n   = 1'b0;
        end else begin
            rx_valid_n = rx_valid_r;
        end
`ifdef UART_PARITY_EN
        rx_perr_n = (rx_done_s & rx_par_bad_r) | (rx_perr_r & ~rx_pop_s);
`endif
    end

    assign reg_dat_do = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign rx_overrun = rx_ovr_r;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_perr_r;
    assign frame_err     = frame_err_r;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Randomised scoreboard bench for uart_core: frame-level reference model, TX and RX monitors.
`timescale 1ns/1ps
module tb_uart_core;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_divider = 16'd8;
    logic        ser_rx, ser_tx;
    logic        rx_drv = 1'b1, loop_en = 1'b0;
    logic [7:0]  reg_dat_di = 8'h00, reg_dat_do;
    logic        reg_dat_we = 1'b0, reg_dat_re = 1'b0;
    logic        tx_busy, rx_valid, rx_overrun;
`ifdef UART_PARITY_EN
    logic        rx_parity_err, frame_err;
`endif

    assign ser_rx = loop_en ? ser_tx : rx_drv;

    uart_core dut (
        .clk(clk), .rst(rst), .cfg_divider(cfg_divider), .ser_rx(ser_rx), .ser_tx(ser_tx),
        .reg_dat_di(reg_dat_di), .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re),
        .reg_dat_do(reg_dat_do), .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_overrun(rx_overrun)
`ifdef UART_PARITY_EN
        , .rx_parity_err(rx_parity_err), .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct { logic [7:0] b; int p; } tx_exp_t;
    tx_exp_t    tx_q[$];
    logic [7:0] rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: bit i of the serial frame for byte b
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        int v;
        v = int'(b);
        if (i == 0) return 1'b0;
        else if (i <= 8) return ((v >> (i - 1)) & 1) == 1;
        else if (NB == 11 && i == 9) return ^b;
        else return 1'b1;
    endfunction

    function automatic int eff_p(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // TX monitor: sample each bit at its midpoint and measure busy length
    initial begin
        bit prev;
        tx_exp_t e;
        logic [10:0] got, exp;
        int k;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && tx_busy && !prev) begin
                if (tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected: got a frame expected none");
                    e.b = 8'h00; e.p = eff_p(int'(cfg_divider));
                end else begin
                    e = tx_q.pop_front();
                end
                got = '0; exp = '0; k = 0;
                for (int i = 0; i < NB; i++) exp[i] = frame_bit(e.b, i);
                while (tx_busy && k < 20000) begin
                    if ((k % e.p) == (e.p / 2) && (k / e.p) < NB) got[k / e.p] = ser_tx;
                    k++;
                    @(negedge clk);
                end
                check("tx_frame", 32'(got), 32'(exp));
                check("tx_busy_len", k, NB * e.p);
                prev = 1'b0;
            end else begin
                prev = tx_busy;
            end
        end
    end

    // RX monitor: each new valid byte is compared against the scoreboard
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && rx_valid && !prev) begin
                if (rx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_unexpected: got %0h expected none", reg_dat_do);
                end else begin
                    check("rx_byte", reg_dat_do, rx_q.pop_front());
                end
            end
            prev = rx_valid;
        end
    end

    task automatic tx_send(input logic [7:0] b, input bit expect_it, input int p);
        if (expect_it) tx_q.push_back('{b: b, p: p});
        reg_dat_di = b;
        reg_dat_we = 1'b1;
        @(negedge clk);
        reg_dat_we = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (tx_busy && n < 20000) begin @(negedge clk); n++; end
        if (n >= 20000) check("tx_idle_timeout", tx_busy, 0);
    endtask

    task automatic wait_rx_valid(input int budget);
        int n = 0;
        while (!rx_valid && n < budget) begin @(negedge clk); n++; end
        check("rx_valid_wait", rx_valid, 1);
    endtask

    task automatic pop_rx();
        reg_dat_re = 1'b1;
        @(negedge clk);
        reg_dat_re = 1'b0;
        check("rx_valid_after_re", rx_valid, 0);
        check("rx_overrun_after_re", rx_overrun, 0);
    endtask

    task automatic send_rx(input logic [7:0] b, input int p, input bit good_stop,
                           input bit par_flip, input bit chk_latency);
        for (int i = 0; i < NB - 1; i++) begin
            rx_drv = frame_bit(b, i) ^ (par_flip && i == 9);
            repeat (p) @(negedge clk);
        end
        rx_drv = good_stop;
        if (chk_latency) begin
            repeat (p / 2 + 3) @(negedge clk);
            check("rx_valid_latency", rx_valid, 1);
            repeat (p - p / 2 - 3) @(negedge clk);
        end else begin
            repeat (p) @(negedge clk);
        end
        if (!good_stop) repeat (2 * p) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * p) @(negedge clk);
    endtask

    initial begin
        #(900000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int d, p;
        repeat (3) @(negedge clk);
        check("rst_ser_tx", ser_tx, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_overrun", rx_overrun, 0);
        check("rst_reg_dat_do", reg_dat_do, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // reset in the middle of a frame
        tx_send(8'h00, 1'b0, 8);
        repeat (20) @(negedge clk);
        check("tx_low_before_rst", ser_tx, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ser_tx", ser_tx, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ser_tx", ser_tx, 1);
        check("post_rst_tx_busy", tx_busy, 0);
        mon_en = 1'b1;

        // A5 frame, second write while busy is ignored
        tx_send(8'hA5, 1'b1, 8);
        repeat (40) @(negedge clk);
        tx_send(8'h5A, 1'b0, 8);
        wait_tx_idle();

        // back-to-back write on the first idle clock
        tx_send(8'hC3, 1'b1, 8);
        wait_tx_idle();
        tx_send(8'h3C, 1'b1, 8);
        check("tx_b2b_accept", tx_busy, 1);
        wait_tx_idle();

        // random TX bytes, including dividers below the floor
        for (int i = 0; i < 6; i++) begin
            d = (i < 2) ? i : int'($urandom_range(0, 12));
            cfg_divider = 16'(d);
            b = 8'($urandom);
            tx_send(b, 1'b1, eff_p(d));
            wait_tx_idle();
            @(negedge clk);
        end

        // directed RX byte with latency check
        cfg_divider = 16'd8;
        rx_q.push_back(8'h3C);
        send_rx(8'h3C, 8, 1'b1, 1'b0, 1'b1);
        check("rx_3c_data", reg_dat_do, 8'h3C);
        pop_rx();

        // overrun
        rx_q.push_back(8'h11);
        send_rx(8'h11, 8, 1'b1, 1'b0, 1'b0);
        send_rx(8'h22, 8, 1'b1, 1'b0, 1'b0);
        check("ovr_data_kept", reg_dat_do, 8'h11);
        check("ovr_flag", rx_overrun, 1);
        check("ovr_valid", rx_valid, 1);
        pop_rx();

        // glitch and framing error produce nothing; FSM recovers
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_byte", rx_valid, 0);
        send_rx(8'hC3, 8, 1'b0, 1'b0, 1'b0);
        check("ferr_no_byte", rx_valid, 0);
        rx_q.push_back(8'h7E);
        send_rx(8'h7E, 8, 1'b1, 1'b0, 1'b0);
        check("recover_7e", reg_dat_do, 8'h7E);
        pop_rx();

        // random RX bytes at random periods
        for (int i = 0; i < 6; i++) begin
            p = int'($urandom_range(4, 16));
            cfg_divider = 16'(p);
            b = 8'($urandom);
            rx_q.push_back(b);
            send_rx(b, p, 1'b1, 1'b0, 1'b0);
            check("rx_rand_valid", rx_valid, 1);
            pop_rx();
        end

`ifdef UART_PARITY_EN
        cfg_divider = 16'd8;
        rx_q.push_back(8'h5A);
        send_rx(8'h5A, 8, 1'b1, 1'b1, 1'b0);
        check("parity_err_set", rx_parity_err, 1);
        reg_dat_re = 1'b1;
        @(negedge clk);
        reg_dat_re = 1'b0;
        check("parity_err_clear", rx_parity_err, 0);
`endif

        // loopback at the 100 MHz / 115200 divider
        cfg_divider = 16'd868;
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'h00 : ((i == 1) ? 8'hFF : 8'h55);
            rx_q.push_back(b);
            tx_send(b, 1'b1, 868);
            wait_rx_valid(NB * 868 + 200);
            pop_rx();
            wait_tx_idle();
            repeat (4) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("tx_queue_drained", tx_q.size(), 0);
        check("rx_queue_drained", rx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Byte-wide UART responder serving the core's memory-mapped UART register interface (tx data/we, rx re/data/valid, tx busy).
- Serialises bytes written by the datapath onto ser_tx and deserialises ser_rx into a one-byte receive buffer the datapath polls and pops.
- Sits between the data_path UART port signals and the board's USB-UART pins, in the fpga_debugger top.
- 8N1 framing, runtime 16-bit bit-period divider: 100 MHz / 115200 bps gives cfg_divider = 868.

Parameters:
- DIV_MIN, 2, floor applied to cfg_divider; smaller values are treated as DIV_MIN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cfg_divider  in  16  clocks per bit period
- ser_rx  in  1  serial input, asynchronous to clk, idle high
- ser_tx  out  1  serial output, idle high
- reg_dat_di  in  8  byte to transmit
- reg_dat_we  in  1  transmit strobe, one clk
- reg_dat_re  in  1  receive pop strobe, one clk
- reg_dat_do  out  8  received byte buffer
- tx_busy  out  1  transmitter occupied
- rx_valid  out  1  reg_dat_do holds an unread byte
- rx_overrun  out  1  sticky: a byte was dropped because the buffer was full

Behaviour:
- Reset is synchronous on rst high:
  - ser_tx=1, tx_busy=0, rx_valid=0, rx_overrun=0, reg_dat_do=8'h00.
  - Both FSMs go to IDLE; the rx synchroniser flops are set to 1.
  - Reset mid-frame aborts immediately; no partial byte is delivered.
- Bit period P = max(cfg_divider, DIV_MIN) clocks. P is latched per direction at frame start; changes mid-frame have no effect until the next frame.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - reg_dat_we in IDLE latches reg_dat_di. tx_busy and ser_tx=0 are registered the next clk.
  - Each state bit lasts exactly P clocks. Data is sent LSB first. Stop bit = 1.
  - tx_busy falls on the clk after the stop period ends. Total busy = 10*P clocks.
  - A back-to-back we on the first clk where tx_busy=0 is accepted with no idle gap.
  - reg_dat_we while tx_busy=1 is ignored silently; the latched byte is unchanged.
- RX synchroniser: 2 flops on ser_rx, with a further flop for falling-edge detect. All RX decisions use the synchronised signal.
- RX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - IDLE: a falling edge starts a counter. At P/2 (integer floor) the line is sampled.
    - Low: enter DATA.
    - High: glitch; return to IDLE.
  - DATA: sample every P clocks at mid-bit, shifting LSB first.
  - STOP: sample at mid-bit.
    - If 1: byte complete; return to IDLE on the same clk.
    - If 0: framing error; byte discarded. Return to IDLE only after the line is seen high; no edge can retrigger while the line stays low.
- Byte completion with rx_valid=0: reg_dat_do <= byte, rx_valid <= 1.
- Byte completion with rx_valid=1 and no reg_dat_re on that clk: byte dropped, reg_dat_do unchanged, rx_overrun <= 1.
- reg_dat_re with rx_valid=1: rx_valid <= 0 and rx_overrun <= 0 next clk. reg_dat_do keeps its value.
- reg_dat_re with rx_valid=0: no effect.
- reg_dat_re and byte completion on the same clk: the new byte is loaded, rx_valid stays 1, no overrun.
- TX and RX are fully independent. Loopback of ser_tx to ser_rx must work.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: frames are 8E1, and two ports are added.
  - A parity bit (XOR of data, even) is sent after bit 7. TX busy = 11*P clocks.
  - RX samples the parity bit. A mismatch sets output rx_parity_err (1 bit, sticky, cleared with rx_overrun by reg_dat_re, reset 0). The byte is still delivered.
  - Output frame_err pulses one clk on a bad stop bit.
- Undefined: 8N1 as above, and neither port exists.

Test Plan:
- Reset with cfg_divider=8 -> ser_tx=1, tx_busy=0, rx_valid=0, rx_overrun=0, reg_dat_do=00. Hold rst 3 clks mid-TX -> ser_tx returns to 1 the clk after rst.
- we with di=8'hA5, cfg_divider=8 -> ser_tx = 0,1,0,1,0,0,1,0,1,1, each bit 8 clks. tx_busy high exactly 80 clks. A second we at clk 40 is ignored.
- Drive 8'h3C on ser_rx at P=8 -> rx_valid rises within 3 clks after the stop-bit midpoint, reg_dat_do=3C. A pulse of re -> rx_valid=0 next clk.
- Send 8'h11 then 8'h22 without re -> reg_dat_do=11, rx_overrun=1. Then re -> both flags clear.
- ser_rx low pulse of 3 clks at P=8 -> no byte. A frame with stop=0 -> no rx_valid, and the FSM recovers for the next valid 8'h7E.
- Loopback ser_tx->ser_rx with cfg_divider=868: send 00, FF, 55 -> each received intact. With UART_PARITY_EN, a forced parity flip -> rx_parity_err=1.
